// File: rtl/spad_seq_if.sv
// Scratchpad sequencer bus: the ifmap stream, the Sram write port and the tap read stream.
interface spad_seq_if #(
    parameter int AW = 4,
    parameter int DW = 16
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_sel;
    logic          wr_en;
    logic [AW-1:0] rd_sel;
    logic          rd_valid;
    logic          rd_last;
    logic          rd_ready;

    modport master (
        input  in_data, in_valid, rd_ready,
        output in_ready, wr_data, wr_sel, wr_en,
        output rd_sel, rd_valid, rd_last
    );

    modport slave (
        output in_data, in_valid, rd_ready,
        input  in_ready, wr_data, wr_sel, wr_en,
        input  rd_sel, rd_valid, rd_last
    );
endinterface

// File: rtl/spad_seq.sv
// Fills a circular scratchpad from the ifmap stream and sweeps 1-D conv windows out of it.
// Optional SPAD_SEQ_STRIDE_EN adds cfg_stride (words per slide); otherwise the stride is 1.
module spad_seq #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic          CLK,
    input  logic          clr_,
    input  logic          start,
    input  logic [AW:0]   cfg_taps,
    input  logic [7:0]    cfg_wins,
`ifdef SPAD_SEQ_STRIDE_EN
    input  logic [AW:0]   cfg_stride,
`endif
    spad_seq_if.master    bus,
    output logic          busy,
    output logic          done
);
    typedef enum logic [2:0] {IDLE, FILL, READ, SLIDE, DONE} state_t;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_T   = 1;
    localparam logic [AW-1:0] ONE_A   = 1;
    localparam logic [7:0]    ONE_W   = 1;

    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW:0]   tap_q, tap_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW:0]   taps_q, taps_d;
    logic [AW:0]   strd_q, strd_d;
    logic [7:0]    win_q, win_d;
    logic [7:0]    wins_q, wins_d;

    logic          cfg_ok;
    logic          hs;
    logic          tap_last;
    logic [AW:0]   stride_in;

`ifdef SPAD_SEQ_STRIDE_EN
    assign stride_in = cfg_stride;
    assign cfg_ok = (cfg_taps != '0) && (cfg_taps <= DEPTH_W) &&
                    (cfg_wins != '0) && (cfg_stride != '0) &&
                    (cfg_stride <= cfg_taps);
`else
    assign stride_in = ONE_T;
    assign cfg_ok = (cfg_taps != '0) && (cfg_taps <= DEPTH_W) &&
                    (cfg_wins != '0);
`endif

    assign bus.in_ready = (state_q == FILL) || (state_q == SLIDE);
    assign hs           = bus.in_valid && bus.in_ready;
    assign bus.wr_en    = hs;
    assign bus.wr_data  = bus.in_data;
    assign bus.wr_sel   = wptr_q;
    assign tap_last     = (tap_q == taps_q - ONE_T);
    // Base plus tap offset wraps naturally through AW-bit truncation.
    assign bus.rd_sel   = base_q + tap_q[AW-1:0];
    assign bus.rd_valid = (state_q == READ);
    assign bus.rd_last  = (state_q == READ) && tap_last;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        base_d  = base_q;
        tap_d   = tap_q;
        cnt_d   = cnt_q;
        taps_d  = taps_q;
        strd_d  = strd_q;
        win_d   = win_q;
        wins_d  = wins_q;
        unique case (state_q)
            IDLE: begin
                if (start && cfg_ok) begin
                    state_d = FILL;
                    taps_d  = cfg_taps;
                    wins_d  = cfg_wins;
                    strd_d  = stride_in;
                    wptr_d  = '0;
                    base_d  = '0;
                    tap_d   = '0;
                    cnt_d   = '0;
                    win_d   = '0;
                end
            end
            FILL: begin
                if (hs) begin
                    wptr_d = wptr_q + ONE_A;
                    cnt_d  = cnt_q + ONE_T;
                    if (cnt_q == taps_q - ONE_T) begin
                        state_d = READ;
                        tap_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            READ: begin
                if (bus.rd_ready) begin
                    tap_d = tap_q + ONE_T;
                    if (tap_last) begin
                        tap_d   = '0;
                        win_d   = win_q + ONE_W;
                        state_d = (win_q + ONE_W == wins_q) ? DONE : SLIDE;
                    end
                end
            end
            SLIDE: begin
                if (hs) begin
                    wptr_d = wptr_q + ONE_A;
                    base_d = base_q + ONE_A;
                    cnt_d  = cnt_q + ONE_T;
                    if (cnt_q == strd_q - ONE_T) begin
                        state_d = READ;
                        cnt_d   = '0;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge clr_) begin
        if (!clr_) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            base_q  <= '0;
            tap_q   <= '0;
            cnt_q   <= '0;
            taps_q  <= '0;
            strd_q  <= '0;
            win_q   <= '0;
            wins_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            base_q  <= base_d;
            tap_q   <= tap_d;
            cnt_q   <= cnt_d;
            taps_q  <= taps_d;
            strd_q  <= strd_d;
            win_q   <= win_d;
            wins_q  <= wins_d;
        end
    end
endmodule

// File: tb/tb_spad_seq.sv
// Directed bench for spad_seq: job table plus hand-written reset and ignored-start cases.
module tb_spad_seq;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    typedef struct {
        int r;
        int w;
        int s;
        int v0;
        int stall_tap;
        int stall_n;
        bit restart;
    } job_t;

    typedef struct packed {
        logic [AW-1:0] sel;
        logic          last;
        logic [DW-1:0] data;
    } tap_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   cfg_taps = '0;
    logic [7:0]    cfg_wins = '0;
`ifdef SPAD_SEQ_STRIDE_EN
    logic [AW:0]   cfg_stride = 1;
`endif
    logic          busy;
    logic          done;
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mem [DEPTH];
    tap_t          cap[$];
    job_t          jobs[$];
    tap_t          exp2 [6];

    spad_seq_if #(.AW(AW), .DW(DW)) bus();

    spad_seq #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK        (clk),
        .clr_       (rst_n),
        .start      (start),
        .cfg_taps   (cfg_taps),
        .cfg_wins   (cfg_wins),
`ifdef SPAD_SEQ_STRIDE_EN
        .cfg_stride (cfg_stride),
`endif
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Sram model: a written word is readable from the next cycle on.
    always @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_sel] <= bus.wr_data;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start(int r, int w, int s);
        @(negedge clk);
        start    = 1'b1;
        cfg_taps = r[AW:0];
        cfg_wins = w[7:0];
`ifdef SPAD_SEQ_STRIDE_EN
        cfg_stride = s[AW:0];
`else
        if (s != 1) $display("note: stride %0d needs SPAD_SEQ_STRIDE_EN", s);
`endif
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_job(job_t j);
        int k = 0;
        int t = 0;
        int wi = 0;
        int total = j.r + (j.w - 1) * j.s;
        int stalls = 0;
        int held = 0;
        bit hs = 0;
        bit fin = 0;
        bit rs_done = 0;
        cap.delete();
        bus.in_data  = DW'(j.v0);
        bus.in_valid = 1'b1;
        bus.rd_ready = 1'b1;
        pulse_start(j.r, j.w, j.s);
        chk("busy_after_start", 32'(busy), 1);
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start = 1'b0;
            if (hs) begin
                k++;
                bus.in_data = DW'(j.v0 + k);
            end
            hs = 0;
            if (done) begin
                chk("busy_in_done", 32'(busy), 1);
                chk("windows_read", wi, j.w);
                chk("words_taken", k, total);
                fin = 1;
            end
            if (bus.in_ready) begin
                chk("extra_word", 32'(k < total), 1);
                chk("wr_sel", 32'(bus.wr_sel), k % DEPTH);
                chk("wr_en", 32'(bus.wr_en), 1);
                chk("rd_valid_when_writing", 32'(bus.rd_valid), 0);
                hs = 1;
            end
            if (bus.rd_valid) begin
                bus.rd_ready = 1'b1;
                if (t == j.stall_tap && wi == 0) begin
                    held++;
                    if (stalls < j.stall_n) begin
                        bus.rd_ready = 1'b0;
                        stalls++;
                    end
                end
                if (j.restart && !rs_done) begin
                    start    = 1'b1;
                    cfg_taps = 5;
                    cfg_wins = 9;
                    rs_done  = 1;
                end
                chk("rd_sel", 32'(bus.rd_sel), (wi * j.s + t) % DEPTH);
                chk("rd_last", 32'(bus.rd_last), 32'(t == j.r - 1));
                chk("rd_data", 32'(mem[bus.rd_sel]), 32'(j.v0 + wi * j.s + t));
                if (bus.rd_ready) begin
                    cap.push_back('{bus.rd_sel, bus.rd_last, mem[bus.rd_sel]});
                    t++;
                    if (t == j.r) begin
                        t = 0;
                        wi++;
                    end
                end
            end
        end
        start = 1'b0;
        if (!fin) chk("done_timeout", 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("done_one_cycle", 32'(done), 0);
        chk("busy_after_done", 32'(busy), 0);
        if (j.stall_tap >= 0) chk("held_cycles", held, j.stall_n + 1);
    endtask

    task automatic expect_ignored(string name);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_in_ready"}, 32'(bus.in_ready), 0);
        @(negedge clk);
        chk({name, "_done"}, 32'(done), 0);
        chk({name, "_busy2"}, 32'(busy), 0);
    endtask

    initial begin
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.rd_ready = 1'b0;
        exp2 = '{'{4'd0, 1'b0, 16'd10}, '{4'd1, 1'b0, 16'd11},
                 '{4'd2, 1'b1, 16'd12}, '{4'd1, 1'b0, 16'd11},
                 '{4'd2, 1'b0, 16'd12}, '{4'd3, 1'b1, 16'd13}};
        jobs.push_back('{3, 2, 1, 10, -1, 0, 0});
        jobs.push_back('{16, 3, 1, 200, -1, 0, 0});
        jobs.push_back('{2, 1, 1, 50, 1, 3, 0});
        jobs.push_back('{4, 3, 1, 300, -1, 0, 1});
        jobs.push_back('{1, 4, 1, 70, 0, 2, 0});
`ifdef SPAD_SEQ_STRIDE_EN
        jobs.push_back('{4, 2, 2, 400, -1, 0, 0});
        jobs.push_back('{16, 2, 16, 500, -1, 0, 0});
`endif

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        rst_n = 1'b1;

        // Reset while a window is being read
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd5;
        bus.rd_ready = 1'b0;
        pulse_start(4, 1, 1);
        for (int i = 0; i < 20 && !bus.rd_valid; i++) @(negedge clk);
        chk("t1_in_read", 32'(bus.rd_valid), 1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t1_in_ready", 32'(bus.in_ready), 0);
        chk("t1_wr_en", 32'(bus.wr_en), 0);
        chk("t1_rd_valid", 32'(bus.rd_valid), 0);
        chk("t1_rd_last", 32'(bus.rd_last), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_done", 32'(done), 0);
        chk("t1_wr_sel", 32'(bus.wr_sel), 0);
        chk("t1_rd_sel", 32'(bus.rd_sel), 0);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;

        foreach (jobs[n]) begin
            run_job(jobs[n]);
            if (n == 0) begin
                chk("t2_tap_count", cap.size(), 6);
                for (int i = 0; i < 6 && i < cap.size(); i++) begin
                    chk("t2_sel", 32'(cap[i].sel), 32'(exp2[i].sel));
                    chk("t2_last", 32'(cap[i].last), 32'(exp2[i].last));
                    chk("t2_data", 32'(cap[i].data), 32'(exp2[i].data));
                end
            end
        end

        // Illegal configurations are ignored
        pulse_start(0, 2, 1);
        expect_ignored("taps0");
        pulse_start(17, 2, 1);
        expect_ignored("taps17");
        pulse_start(3, 0, 1);
        expect_ignored("wins0");
`ifdef SPAD_SEQ_STRIDE_EN
        pulse_start(3, 2, 0);
        expect_ignored("stride0");
        pulse_start(2, 2, 3);
        expect_ignored("stride_gt_r");
`endif

        run_job('{3, 2, 1, 10, -1, 0, 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
